// File: rtl/capturador_de_requisicao_pkg.sv
// Shared types and constants for the request-capture front end.
// Request codes are 3-bit user plus 3-bit functionality.
package pkg_requisicao;

  localparam int USER_W = 3;
  localparam int FUNC_W = 3;

  localparam logic [FUNC_W-1:0] FUNC_NEUTRO = 3'b000;

  typedef enum logic [1:0] {
    OCIOSO,
    VALIDO,
    ESPERA_SOLTAR
  } estado_t;

  // Buttons are active-low; the function code wants them active-high.
  function automatic logic [FUNC_W-1:0] forma_func(
    input logic       sw,
    input logic [1:0] btn_n
  );
    return {sw, ~btn_n[0], ~btn_n[1]};
  endfunction

endpackage

// File: rtl/capturador_de_requisicao_if.sv
// Request bus between the capture front end and its consumer.
// master drives codes/valid/timeout, slave drives ready.
interface capturador_de_requisicao_if;
  import pkg_requisicao::*;

  logic [USER_W-1:0] User0;
  logic [FUNC_W-1:0] Func0;
  logic              Valid0;
  logic              Ready0;
  logic              Timeout0;

  logic [USER_W-1:0] User1;
  logic [FUNC_W-1:0] Func1;
  logic              Valid1;
  logic              Ready1;
  logic              Timeout1;

  modport master (
    output User0, Func0, Valid0, Timeout0,
    output User1, Func1, Valid1, Timeout1,
    input  Ready0, Ready1
  );

  modport slave (
    input  User0, Func0, Valid0, Timeout0,
    input  User1, Func1, Valid1, Timeout1,
    output Ready0, Ready1
  );

endinterface

// File: rtl/capturador_de_requisicao_filtro.sv
// Single-bit 2-flop synchronizer followed by a counting debouncer.
// RST_VAL sets the idle level of both synchronizer and output.
module filtro_de_ruido #(
  parameter int   DEBOUNCE_CYCLES = 250000,
  parameter int   CNT_W           = 18,
  parameter logic RST_VAL         = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean
);

  localparam logic [CNT_W-1:0] LIMITE =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic             clean_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= RST_VAL;
      s2_q    <= RST_VAL;
      clean_q <= RST_VAL;
      cnt_q   <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      if (s2_q != clean_q) begin
        if (cnt_q == LIMITE) begin
          clean_q <= s2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign clean = clean_q;

endmodule

// File: rtl/capturador_de_requisicao.sv
// Switch/button capture: filter, form codes, one request per press.
// Optional request abort after a wait: define CAPTURADOR_TIMEOUT_EN.
module capturador_de_requisicao
  import pkg_requisicao::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
`ifdef CAPTURADOR_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES  = 50000000
`endif
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic [7:0] CH,
  input  logic [3:0] BTN,
  capturador_de_requisicao_if.master bus
);

`ifdef CAPTURADOR_TIMEOUT_EN
  localparam int TMO_W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LIM =
    TMO_W'(TIMEOUT_CYCLES - 1);
`endif

  logic [7:0]          ch_db;
  logic [3:0]          btn_db;
  logic [1:0]          ready_v;
  logic [1:0]          valid_v;
  logic [1:0]          tmo_v;
  logic [2*USER_W-1:0] user_v;
  logic [2*FUNC_W-1:0] func_v;

  for (genvar i = 0; i < 8; i++) begin : g_ch
    filtro_de_ruido #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .RST_VAL        (1'b0)
    ) u_filtro (
      .clk  (Clock),
      .rst_n(Reset_n),
      .raw  (CH[i]),
      .clean(ch_db[i])
    );
  end

  for (genvar i = 0; i < 4; i++) begin : g_btn
    filtro_de_ruido #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .RST_VAL        (1'b1)
    ) u_filtro (
      .clk  (Clock),
      .rst_n(Reset_n),
      .raw  (BTN[i]),
      .clean(btn_db[i])
    );
  end

  assign ready_v = {bus.Ready1, bus.Ready0};

  for (genvar c = 0; c < 2; c++) begin : g_canal
    localparam int B = 4 * c;

    logic [USER_W-1:0] user_in;
    logic [FUNC_W-1:0] func_in;
    logic [USER_W-1:0] user_q, user_d;
    logic [FUNC_W-1:0] func_q, func_d;
    logic              valid_q, valid_d;
    logic              ready;
    estado_t           est_q, est_d;
`ifdef CAPTURADOR_TIMEOUT_EN
    logic [TMO_W-1:0]  tcnt_q, tcnt_d;
    logic              tmo_q, tmo_d;
`endif

    assign user_in = {ch_db[B], ch_db[B+1], ch_db[B+2]};
    assign func_in = forma_func(ch_db[B+3], btn_db[2*c +: 2]);
    assign ready   = ready_v[c];

    always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
        est_q   <= OCIOSO;
        user_q  <= '0;
        func_q  <= '0;
        valid_q <= 1'b0;
`ifdef CAPTURADOR_TIMEOUT_EN
        tcnt_q  <= '0;
        tmo_q   <= 1'b0;
`endif
      end else begin
        est_q   <= est_d;
        user_q  <= user_d;
        func_q  <= func_d;
        valid_q <= valid_d;
`ifdef CAPTURADOR_TIMEOUT_EN
        tcnt_q  <= tcnt_d;
        tmo_q   <= tmo_d;
`endif
      end
    end

    always_comb begin
      est_d   = est_q;
      user_d  = user_q;
      func_d  = func_q;
      valid_d = valid_q;
`ifdef CAPTURADOR_TIMEOUT_EN
      tcnt_d  = tcnt_q;
      tmo_d   = 1'b0;
`endif
      unique case (est_q)
        OCIOSO: begin
          if (func_in != FUNC_NEUTRO) begin
            user_d  = user_in;
            func_d  = func_in;
            valid_d = 1'b1;
            est_d   = VALIDO;
`ifdef CAPTURADOR_TIMEOUT_EN
            tcnt_d  = '0;
`endif
          end
        end
        VALIDO: begin
          // Acceptance wins over a coincident timeout.
          if (ready) begin
            valid_d = 1'b0;
            est_d   = ESPERA_SOLTAR;
          end
`ifdef CAPTURADOR_TIMEOUT_EN
          else if (tcnt_q == TMO_LIM) begin
            valid_d = 1'b0;
            tmo_d   = 1'b1;
            est_d   = ESPERA_SOLTAR;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
`endif
        end
        ESPERA_SOLTAR: begin
          if (func_in == FUNC_NEUTRO) begin
            est_d = OCIOSO;
          end
        end
        default: est_d = OCIOSO;
      endcase
    end

    assign valid_v[c]                 = valid_q;
    assign user_v[c*USER_W +: USER_W] = user_q;
    assign func_v[c*FUNC_W +: FUNC_W] = func_q;
`ifdef CAPTURADOR_TIMEOUT_EN
    assign tmo_v[c]                   = tmo_q;
`else
    assign tmo_v[c]                   = 1'b0;
`endif
  end

  assign bus.User0    = user_v[USER_W-1:0];
  assign bus.Func0    = func_v[FUNC_W-1:0];
  assign bus.Valid0   = valid_v[0];
  assign bus.Timeout0 = tmo_v[0];
  assign bus.User1    = user_v[2*USER_W-1:USER_W];
  assign bus.Func1    = func_v[2*FUNC_W-1:FUNC_W];
  assign bus.Valid1   = valid_v[1];
  assign bus.Timeout1 = tmo_v[1];

endmodule

// File: tb/tb_capturador_de_requisicao.sv
// Bench for capturador_de_requisicao: vector table, corner sequences,
// and random stimulus against a sliding-window reference model.
module tb_capturador_de_requisicao;

  localparam int DC = 4;
  localparam int TO = 16;
`ifdef CAPTURADOR_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic       Clock = 1'b0;
  logic       Reset_n;
  logic [7:0] CH;
  logic [3:0] BTN;

  capturador_de_requisicao_if bus();

  capturador_de_requisicao #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (3)
`ifdef CAPTURADOR_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (TO)
`endif
  ) dut (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .CH     (CH),
    .BTN    (BTN),
    .bus    (bus)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference: debounced bit flips when its last DC synced samples
  // (raw delayed two edges) all disagree with it.
  localparam logic [11:0] RST12 = {4'hF, 8'h00};

  logic [11:0] m_hist[$];
  logic [11:0] m_deb;
  logic [1:0]  m_valid, m_wait, m_tmo;
  logic [2:0]  m_user[2];
  logic [2:0]  m_func[2];
  int          m_tcnt[2];

  function automatic void model_reset();
    m_hist = {};
    for (int i = 0; i < DC + 2; i++) m_hist.push_back(RST12);
    m_deb   = RST12;
    m_valid = '0;
    m_wait  = '0;
    m_tmo   = '0;
    for (int c = 0; c < 2; c++) begin
      m_user[c] = '0;
      m_func[c] = '0;
      m_tcnt[c] = 0;
    end
  endfunction

  function automatic void model_edge(input logic [11:0] raw,
                                     input logic [1:0]  rdy);
    int n;
    bit diff;
    logic [11:0] nd;
    for (int c = 0; c < 2; c++) begin
      int b = 4 * c;
      logic [2:0] u, f;
      u = {m_deb[b], m_deb[b+1], m_deb[b+2]};
      f = {m_deb[b+3], ~m_deb[8+2*c], ~m_deb[9+2*c]};
      m_tmo[c] = 1'b0;
      if (m_valid[c]) begin
        if (rdy[c]) begin
          m_valid[c] = 1'b0;
          m_wait[c]  = 1'b1;
        end else if (TMO_ON) begin
          m_tcnt[c]++;
          if (m_tcnt[c] == TO) begin
            m_valid[c] = 1'b0;
            m_wait[c]  = 1'b1;
            m_tmo[c]   = 1'b1;
          end
        end
      end else if (m_wait[c]) begin
        if (f == 3'b000) m_wait[c] = 1'b0;
      end else if (f != 3'b000) begin
        m_valid[c] = 1'b1;
        m_user[c]  = u;
        m_func[c]  = f;
        m_tcnt[c]  = 0;
      end
    end
    m_hist.push_back(raw);
    while (m_hist.size() > DC + 2) void'(m_hist.pop_front());
    n  = m_hist.size();
    nd = m_deb;
    for (int i = 0; i < 12; i++) begin
      diff = 1'b1;
      for (int j = 0; j < DC; j++)
        if (m_hist[n-3-j][i] == m_deb[i]) diff = 1'b0;
      if (diff) nd[i] = ~m_deb[i];
    end
    m_deb = nd;
  endfunction

  task automatic model_cmp();
    chk("m_valid0", 8'(bus.Valid0), 8'(m_valid[0]));
    chk("m_valid1", 8'(bus.Valid1), 8'(m_valid[1]));
    chk("m_tmo0", 8'(bus.Timeout0), 8'(m_tmo[0]));
    chk("m_tmo1", 8'(bus.Timeout1), 8'(m_tmo[1]));
    if (m_valid[0]) begin
      chk("m_user0", 8'(bus.User0), 8'(m_user[0]));
      chk("m_func0", 8'(bus.Func0), 8'(m_func[0]));
    end
    if (m_valid[1]) begin
      chk("m_user1", 8'(bus.User1), 8'(m_user[1]));
      chk("m_func1", 8'(bus.Func1), 8'(m_func[1]));
    end
  endtask

  task automatic step();
    @(posedge Clock);
    if (Reset_n) model_edge({BTN, CH}, {bus.Ready1, bus.Ready0});
    #1;
    model_cmp();
  endtask

  typedef struct {
    logic [7:0] ch;
    logic [3:0] btn;
    logic [1:0] rdy;
    int         n;
    logic [1:0] ev;
    logic [2:0] eu0, ef0, eu1, ef1;
  } vec_t;

  vec_t tab[22];

  initial begin
    tab[0]  = '{8'h05, 4'hE, 2'b00, 6,  2'b00, 0, 0, 0, 0};
    tab[1]  = '{8'h05, 4'hE, 2'b00, 1,  2'b01, 5, 2, 0, 0};
    tab[2]  = '{8'h05, 4'hE, 2'b00, 10, 2'b01, 5, 2, 0, 0};
    tab[3]  = '{8'h05, 4'hE, 2'b01, 1,  2'b00, 0, 0, 0, 0};
    tab[4]  = '{8'h05, 4'hE, 2'b00, 20, 2'b00, 0, 0, 0, 0};
    tab[5]  = '{8'h05, 4'hF, 2'b00, 8,  2'b00, 0, 0, 0, 0};
    tab[6]  = '{8'h05, 4'hD, 2'b00, 7,  2'b01, 5, 1, 0, 0};
    tab[7]  = '{8'h05, 4'hF, 2'b01, 1,  2'b00, 0, 0, 0, 0};
    tab[8]  = '{8'h05, 4'hF, 2'b00, 8,  2'b00, 0, 0, 0, 0};
    tab[9]  = '{8'h00, 4'hB, 2'b00, 2,  2'b00, 0, 0, 0, 0};
    tab[10] = '{8'h00, 4'hF, 2'b00, 10, 2'b00, 0, 0, 0, 0};
    tab[11] = '{8'h00, 4'h6, 2'b00, 6,  2'b00, 0, 0, 0, 0};
    tab[12] = '{8'h00, 4'h6, 2'b00, 1,  2'b11, 0, 2, 0, 1};
    tab[13] = '{8'h00, 4'h6, 2'b10, 1,  2'b01, 0, 2, 0, 0};
    tab[14] = '{8'h00, 4'h6, 2'b01, 1,  2'b00, 0, 0, 0, 0};
    tab[15] = '{8'h00, 4'hF, 2'b00, 8,  2'b00, 0, 0, 0, 0};
    tab[16] = '{8'h80, 4'hF, 2'b00, 7,  2'b10, 0, 0, 0, 4};
    tab[17] = '{8'h00, 4'hF, 2'b10, 1,  2'b00, 0, 0, 0, 0};
    tab[18] = '{8'h00, 4'hF, 2'b00, 8,  2'b00, 0, 0, 0, 0};
    tab[19] = '{8'h00, 4'hE, 2'b01, 7,  2'b01, 0, 2, 0, 0};
    tab[20] = '{8'h00, 4'hE, 2'b01, 1,  2'b00, 0, 0, 0, 0};
    tab[21] = '{8'h00, 4'hF, 2'b00, 8,  2'b00, 0, 0, 0, 0};
  end

  initial begin
    CH         = 8'h00;
    BTN        = 4'hF;
    bus.Ready0 = 1'b0;
    bus.Ready1 = 1'b0;
    Reset_n    = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", {6'd0, bus.Valid1, bus.Valid0}, 8'h00);
    chk("rst_codes", {2'd0, bus.User0, bus.Func0}, 8'h00);
    chk("rst_tmo", {6'd0, bus.Timeout1, bus.Timeout0}, 8'h00);
    repeat (3) @(posedge Clock);
    #1;
    Reset_n = 1'b1;
    step();

    for (int r = 0; r < 22; r++) begin
      CH         = tab[r].ch;
      BTN        = tab[r].btn;
      bus.Ready0 = tab[r].rdy[0];
      bus.Ready1 = tab[r].rdy[1];
      repeat (tab[r].n) step();
      chk($sformatf("row%0d_v0", r), 8'(bus.Valid0), 8'(tab[r].ev[0]));
      chk($sformatf("row%0d_v1", r), 8'(bus.Valid1), 8'(tab[r].ev[1]));
      if (tab[r].ev[0]) begin
        chk($sformatf("row%0d_u0", r), 8'(bus.User0), 8'(tab[r].eu0));
        chk($sformatf("row%0d_f0", r), 8'(bus.Func0), 8'(tab[r].ef0));
      end
      if (tab[r].ev[1]) begin
        chk($sformatf("row%0d_u1", r), 8'(bus.User1), 8'(tab[r].eu1));
        chk($sformatf("row%0d_f1", r), 8'(bus.Func1), 8'(tab[r].ef1));
      end
    end

    // Reset in the middle of a pending request, button still held.
    CH  = 8'h05;
    BTN = 4'hE;
    bus.Ready0 = 1'b0;
    repeat (7) step();
    chk("pre_rst_v0", 8'(bus.Valid0), 8'h01);
    #2;
    Reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_async_v0", 8'(bus.Valid0), 8'h00);
    @(posedge Clock);
    #1;
    Reset_n = 1'b1;
    repeat (6) step();
    chk("rst_wait_v0", 8'(bus.Valid0), 8'h00);
    step();
    chk("rst_reissue_v0", 8'(bus.Valid0), 8'h01);
    chk("rst_reissue_u0", 8'(bus.User0), 8'h05);
    bus.Ready0 = 1'b1;
    step();
    bus.Ready0 = 1'b0;
    BTN = 4'hF;
    CH  = 8'h00;
    repeat (8) step();

`ifdef CAPTURADOR_TIMEOUT_EN
    BTN = 4'hE;
    repeat (7) step();
    chk("to_rise_v0", 8'(bus.Valid0), 8'h01);
    repeat (15) step();
    chk("to_hold_v0", 8'(bus.Valid0), 8'h01);
    chk("to_hold_t0", 8'(bus.Timeout0), 8'h00);
    step();
    chk("to_drop_v0", 8'(bus.Valid0), 8'h00);
    chk("to_pulse_t0", 8'(bus.Timeout0), 8'h01);
    step();
    chk("to_end_t0", 8'(bus.Timeout0), 8'h00);
    repeat (10) step();
    chk("to_noreissue_v0", 8'(bus.Valid0), 8'h00);
    BTN = 4'hF;
    repeat (8) step();
`endif

    for (int s = 0; s < 250; s++) begin
      int dur;
      CH  = 8'($urandom) & 8'($urandom);
      BTN = 4'($urandom) | 4'($urandom);
      dur = $urandom_range(1, 10);
      for (int k = 0; k < dur; k++) begin
        bus.Ready0 = ($urandom_range(0, 3) == 0);
        bus.Ready1 = ($urandom_range(0, 3) == 0);
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
